// File: rtl/sd_cmd_if.sv
// sd_cmd_if: command request/response handshake plus the CMD pin signals
// between the host control logic (master) and the command engine (slave).
interface sd_cmd_if;
  logic start, ready, cmd_out, cmd_oe, cmd_in, done, crc_err, timeout_err;
  logic [5:0] cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0] resp_type;
  logic [127:0] resp;
  modport master(output start, cmd_index, cmd_arg, resp_type, cmd_in,
                 input ready, cmd_out, cmd_oe, resp, done, crc_err, timeout_err);
  modport slave(input start, cmd_index, cmd_arg, resp_type, cmd_in,
                output ready, cmd_out, cmd_oe, resp, done, crc_err, timeout_err);
endinterface

// File: rtl/sd_cmd_host.sv
// sd_cmd_host: SD CMD-line engine; sends a CRC7-protected command, waits for
// and receives a 48/136-bit response, then pads NCC idle clocks before DONE.
module sd_cmd_host #(
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC = 8
) (
  input logic clk,
  input logic rst_n,
  sd_cmd_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TX, WAIT, RX, FINISH} state_t;
  state_t state, state_d;
  logic [15:0] cnt;
  logic [39:0] tx;
  logic [6:0] crc;
  logic [1:0] rtype;
  logic long_rsp, tx_last, rx_last, wait_exp, fin_last, crc_en, tx_bit;

  function automatic logic [6:0] crc7(input logic [6:0] c, input logic b);
    return {c[5:3], c[2] ^ c[6] ^ b, c[1:0], c[6] ^ b};
  endfunction

  assign long_rsp = rtype == 2'b10;
  assign tx_last = cnt == 16'd47;
  assign rx_last = cnt == (long_rsp ? 16'd134 : 16'd46);
  assign wait_exp = bus.cmd_in && cnt == 16'(RESP_TIMEOUT - 1);
  assign fin_last = cnt == 16'(NCC);
  // the start bit was consumed in WAIT; the R2 header (next 7 bits) is outside the CRC
  assign crc_en = long_rsp ? (cnt >= 16'd7 && cnt <= 16'd126) : cnt <= 16'd38;
  assign tx_bit = cnt < 16'd40 ? tx[39] : cnt < 16'd47 ? crc[6] : 1'b1;
  assign bus.ready = state == IDLE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (bus.start) state_d = TX;
      TX: if (tx_last) state_d = rtype == 2'b00 ? FINISH : WAIT;
      WAIT: if (!bus.cmd_in) state_d = RX; else if (wait_exp) state_d = FINISH;
      RX: if (rx_last) state_d = FINISH;
      FINISH: if (fin_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      tx <= '0;
      crc <= '0;
      rtype <= '0;
      bus.cmd_oe <= 1'b0;
      bus.cmd_out <= 1'b1;
      bus.done <= 1'b0;
      bus.crc_err <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.resp <= '0;
    end else begin
      cnt <= (state_d != state || state == IDLE) ? '0 : cnt + 16'd1;
      bus.cmd_oe <= state == TX;
      bus.cmd_out <= state != TX || tx_bit;
      bus.done <= state == FINISH && fin_last;
      if (state == IDLE && bus.start) begin
        tx <= {2'b01, bus.cmd_index, bus.cmd_arg};
        rtype <= bus.resp_type;
        bus.crc_err <= 1'b0;
        bus.timeout_err <= 1'b0;
        bus.resp <= '0;
      end
      if (state == TX) begin
        tx <= {tx[38:0], 1'b0};
        crc <= cnt < 16'd40 ? crc7(crc, tx[39]) : {crc[5:0], 1'b0};
      end else if (state == RX) begin
        if (crc_en) crc <= crc7(crc, bus.cmd_in);
        // a short frame's final shift realigns to index/argument fields only
        bus.resp <= rx_last && !long_rsp ? {90'd0, bus.resp[44:7]} : {bus.resp[126:0], bus.cmd_in};
        if (rx_last) bus.crc_err <= !bus.cmd_in || (rtype != 2'b11 && bus.resp[6:0] != crc);
      end else begin
        crc <= '0;
      end
      if (state == WAIT && wait_exp) bus.timeout_err <= 1'b1;
    end
endmodule

// File: doc/sd_cmd_host.md
# sd_cmd_host

Command-line engine for the SD host controller. Runs on the divided card clock produced by the SD clock divider (its `SD_CLK` output drives `CLK` here). It does four things:
- serializes a 48-bit SD command frame with CRC7 onto the CMD line;
- releases the line and waits a bounded time for the card's response start bit;
- deserializes a 48-bit or 136-bit response and checks its CRC7;
- reports completion and error status to the register/control logic.

## Interface
Parameters:
- `RESP_TIMEOUT`, default 64: maximum `CLK` cycles waited for a response start bit (Ncr limit).
- `NCC`, default 8: idle cycles inserted before `DONE`, so the card gets its required trailing clocks.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: card clock, the `SD_CLK` from the clock divider.
- `RST_N` in 1: asynchronous active-low reset.
- `START` in 1: request pulse; accepted only when `READY`=1.
- `CMD_INDEX` in 6: command index.
- `CMD_ARG` in 32: command argument.
- `RESP_TYPE` in 2: 00 none, 01 short with CRC, 10 long (R2), 11 short without CRC check (R3).
- `READY` out 1: idle, able to accept `START`.
- `CMD_OUT` out 1: CMD line drive value.
- `CMD_OE` out 1: CMD line output enable.
- `CMD_IN` in 1: CMD line sampled value.
- `RESP` out 128: received response.
- `DONE` out 1: one-cycle completion pulse.
- `CRC_ERR` out 1: response CRC7 mismatch or end bit ≠ 1.
- `TIMEOUT_ERR` out 1: no start bit seen within `RESP_TIMEOUT` cycles.

## Operation
- States: IDLE, TX, WAIT, RX, FINISH.
- **IDLE** (`READY`=1):
  - On `START`=1, latch index, argument and type into a 40-bit frame {0,1,`CMD_INDEX`,`CMD_ARG`}.
  - Clear `CRC_ERR`, `TIMEOUT_ERR` and `RESP`.
  - Go to TX. `READY` drops the next cycle.
- **TX**: 48 bits, MSB first: frame bits 47..8, then CRC7, then end bit 1.
  - CRC7 polynomial is x^7+x^3+1, initial 0, computed serially over bits 47..8.
  - `CMD_OE`=1 for exactly these 48 cycles.
  - After the last bit: `RESP_TYPE`=00 goes to FINISH; any other type goes to WAIT.
- **WAIT**: `CMD_OE`=0. A counter increments each cycle `CMD_IN`=1.
  - `CMD_IN`=0 is the start bit: go to RX.
  - Counter reaching `RESP_TIMEOUT` sets `TIMEOUT_ERR` and goes to FINISH.
- **RX**: shifts in the remaining 47 bits (short) or 135 bits (long).
  - Short: `RESP[37:32]`=index field, `RESP[31:0]`=argument field, `RESP[127:38]`=0. CRC7 runs over bits 47..8. Type 11 skips the CRC compare but still checks the end bit.
  - Long: `RESP[127:0]`=frame bits 127:0, i.e. the register content with CRC7 and end bit in `[7:0]`. CRC7 runs over frame bits 127:8; the 8 header bits are excluded.
  - A mismatch or end bit 0 sets `CRC_ERR`.
  - Go to FINISH.
- **FINISH**: `NCC` cycles with the line released, then `DONE`=1 for one cycle. The state returns to IDLE in that same cycle, with `READY`=1.
- `START` while `READY`=0 is ignored.
- `RESP` and the error flags hold their values until the next accepted `START`.
- Reset:
  - Asynchronous, from any state.
  - Forces IDLE and clears all outputs. The line is released immediately; no partial frame resumes.

## Timing
- Reset values: `READY`=1, `CMD_OE`=0, `CMD_OUT`=1, `DONE`=0, `CRC_ERR`=0, `TIMEOUT_ERR`=0, `RESP`=0.
- All outputs are registered on rising `CLK`; `CMD_IN` is sampled on rising `CLK`.
- Cycle numbering, with `START` sampled at edge T0:
  - `CMD_OE`=1 and `CMD_OUT` = frame bit 47 (0) from T1.
  - Bit 0 (end bit 1) is driven at T48.
  - `CMD_OE`=0 from T49.
- `RESP_TYPE`=00: `DONE` at T49+`NCC` (T57 at default).
- Response: start bit sampled at edge W. Final bit sampled at W+47 (short) or W+135 (long). `DONE` at that edge +1+`NCC`.
- Timeout: with no start bit, `TIMEOUT_ERR` is set after `RESP_TIMEOUT` sampled cycles of `CMD_IN`=1 in WAIT. `DONE` follows `NCC`+1 cycles later.
- A start bit arriving on the same cycle the counter would expire counts as a response, not a timeout.
- Minimum gap between consecutive commands: one IDLE cycle, because `START` is accepted on the `DONE` cycle at the earliest.

## Test plan
- **CMD0, type none**: index 0, arg 0x00000000.
  - Required: `CMD_OUT` over T1..T48 is 0x400000000095.
  - Required: `CMD_OE` high exactly 48 cycles, `DONE` at T57, no errors.
- **CMD8, type short**: arg 0x000001AA.
  - Required: frame 0x48000001AA87.
  - Bench returns 0x08000001AA plus the correct CRC and end bit, 3 cycles after `CMD_OE` falls.
  - Required: `RESP[37:0]`=0x08000001AA, `CRC_ERR`=0.
- **Corrupted short response**: same as above with one argument bit flipped.
  - Required: `CRC_ERR`=1. `RESP` still holds the received value.
  - Repeat with type 11 and a bad CRC: required `CRC_ERR`=0.
- **Long response (CMD2)**: bench drives a 136-bit R2 frame with a known 128-bit CID.
  - Required: `RESP` equals the CID.
  - Repeat with the end bit forced to 0: required `CRC_ERR`=1.
- **Timeout**: `CMD_IN` held at 1 after a short command.
  - Required: `TIMEOUT_ERR`=1 after 64 cycles, `DONE` 9 cycles later.
  - Also required: a start bit on cycle 64 yields no timeout.
- **Reset and busy behaviour**:
  - Assert `RST_N`=0 mid-TX (around bit 20). Required: `CMD_OE`=0 and `READY`=1 immediately.
  - A `START` issued mid-RX is ignored. Required: frame timing unchanged.
